uart_mmio_ctrl: RTL and testbench

// - Memory-mapped serial-port responder: the target end of the CPU's mem_serial_ce_o data-bus requests.
// - Decodes CPU loads and stores into a DATA register and a STATUS register.
// - Buffers TX and RX bytes in FIFOs and handshakes with the async_transmitter/async_receiver byte interface.
// - Sits between openmips and the UART cores on the CPU clock domain.
//   RX strobes arrive already synchronised to clk.

---
 rtl/uart_mmio_pkg.sv | 25 ++
 rtl/sync_fifo.sv | 62 ++++++
 rtl/uart_mmio_ctrl.sv | 153 +++++++++++++++
 tb/tb_uart_mmio_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_mmio_pkg.sv
// Shared constants and types for the memory-mapped UART controller.
package uart_mmio_pkg;

    // addr_i[2] decode
    localparam logic ADDR_DATA   = 1'b0;
    localparam logic ADDR_STATUS = 1'b1;

    // STATUS register bit positions
    localparam int unsigned TX_READY = 0;
    localparam int unsigned RX_AVAIL = 1;
    localparam int unsigned TX_OVF   = 2;
    localparam int unsigned RX_OVF   = 3;

    // Cycles spent waiting for the transmitter to raise busy before giving up
    localparam int unsigned WAIT_H_TIMEOUT = 16;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StStart,
        StWaitH,
        StWaitL
    } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head output and occupancy count.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty = (count == '0);
    assign full  = (count == FULL_COUNT);
    assign dout  = mem[rd_ptr];

    // A push into a full FIFO is accepted only when a pop frees a slot in the same cycle
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // Storage array; contents need no reset since count guards every read
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_mmio_ctrl.sv
// Bus-facing UART responder: DATA/STATUS registers, TX/RX FIFOs and the
// transmitter start/busy handshake.
module uart_mmio_ctrl
    import uart_mmio_pkg::*;
#(
    parameter int unsigned TX_DEPTH = 16,
    parameter int unsigned RX_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [3:0]  sel_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        tx_start_o,
    output logic [7:0]  tx_data_o,
    input  logic        tx_busy_i,
    input  logic        rx_valid_i,
    input  logic [7:0]  rx_data_i
);

    localparam logic [3:0] WAIT_LAST = 4'(WAIT_H_TIMEOUT - 1);

    tx_state_t  state;
    logic [3:0] wait_cnt;

    logic       tx_full, tx_empty, tx_pop;
    logic [7:0] tx_dout;
    logic       rx_full, rx_empty, rx_pop;
    logic [7:0] rx_dout;

    logic       rd_data, wr_data, wr_status;
    logic       tx_drop, rx_drop;
    logic       tx_ovf, rx_ovf;
    logic [3:0] status;
    logic       unused;

    // Only addr_i[2], sel_i[0] and the low data byte carry meaning
    assign unused = ^{addr_i[31:3], addr_i[1:0], sel_i[3:1], data_i[31:8]};

    assign rd_data   = ce_i & ~we_i & (addr_i[2] == ADDR_DATA);
    assign wr_data   = ce_i & we_i & sel_i[0] & (addr_i[2] == ADDR_DATA);
    assign wr_status = ce_i & we_i & sel_i[0] & (addr_i[2] == ADDR_STATUS);

    assign rx_pop  = rd_data & ~rx_empty;
    assign tx_pop  = (state == StLoad) & ~tx_empty;

    // A byte is lost only when its FIFO is full and nothing leaves it this cycle
    assign rx_drop = rx_valid_i & rx_full & ~rx_pop;
    assign tx_drop = wr_data & tx_full & ~tx_pop;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wr_data),
        .pop   (tx_pop),
        .din   (data_i[7:0]),
        .dout  (tx_dout),
        .full  (tx_full),
        .empty (tx_empty)
    );

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_valid_i),
        .pop   (rx_pop),
        .din   (rx_data_i),
        .dout  (rx_dout),
        .full  (rx_full),
        .empty (rx_empty)
    );

    // Assemble STATUS and steer load data onto the bus
    always_comb begin
        status           = '0;
        status[TX_READY] = ~tx_full;
        status[RX_AVAIL] = ~rx_empty;
        status[TX_OVF]   = tx_ovf;
        status[RX_OVF]   = rx_ovf;

        data_o = '0;
        if (ce_i && !we_i) begin
            if (addr_i[2] == ADDR_STATUS) begin
                data_o = {28'b0, status};
            end else if (!rx_empty) begin
                data_o = {24'b0, rx_dout};
            end
        end
    end

    // Sticky overflow flags: write-1-to-clear, a coincident overflow wins
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_ovf <= 1'b0;
            rx_ovf <= 1'b0;
        end else begin
            tx_ovf <= tx_drop | (tx_ovf & ~(wr_status & data_i[TX_OVF]));
            rx_ovf <= rx_drop | (rx_ovf & ~(wr_status & data_i[RX_OVF]));
        end
    end

    // Transmit sequencer: one byte per transmitter frame, start pulse held high only in StStart
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= StIdle;
            tx_start_o <= 1'b0;
            tx_data_o  <= '0;
            wait_cnt   <= '0;
        end else begin
            tx_start_o <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (!tx_empty && !tx_busy_i) begin
                        state <= StLoad;
                    end
                end
                StLoad: begin
                    tx_data_o  <= tx_dout;
                    tx_start_o <= 1'b1;
                    state      <= StStart;
                end
                StStart: begin
                    wait_cnt <= '0;
                    state    <= StWaitH;
                end
                StWaitH: begin
                    // Guard against a transmitter that never acknowledges the start
                    if (tx_busy_i || wait_cnt == WAIT_LAST) begin
                        state <= StWaitL;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                StWaitL: begin
                    if (!tx_busy_i) begin
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// Self-checking bench for uart_mmio_ctrl with a queue-based reference model.
module tb_uart_mmio_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce_i, we_i;
    logic [31:0] addr_i;
    logic [3:0]  sel_i;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        tx_start_o;
    logic [7:0]  tx_data_o;
    logic        tx_busy_i;
    logic        rx_valid_i;
    logic [7:0]  rx_data_i;

    int checks   = 0;
    int failures = 0;

    // Transmitter model: busy for 10 cycles after each start, or held busy on demand
    logic hold_busy;
    int   busy_cnt = 0;
    logic [7:0] tx_seen[$];

    // Reference model state
    logic [7:0] rx_q[$];
    logic [7:0] tx_exp[$];
    bit         m_tx_ovf, m_rx_ovf;
    int         m_tx_cnt;

    always #5 clk = ~clk;

    assign tx_busy_i = hold_busy | (busy_cnt != 0);

    always @(posedge clk) begin
        if (tx_start_o) busy_cnt <= 10;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end

    always @(posedge clk) begin
        if (tx_start_o) tx_seen.push_back(tx_data_o);
    end

    uart_mmio_ctrl #(
        .TX_DEPTH (16),
        .RX_DEPTH (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ce_i       (ce_i),
        .we_i       (we_i),
        .addr_i     (addr_i),
        .sel_i      (sel_i),
        .data_i     (data_i),
        .data_o     (data_o),
        .tx_start_o (tx_start_o),
        .tx_data_o  (tx_data_o),
        .tx_busy_i  (tx_busy_i),
        .rx_valid_i (rx_valid_i),
        .rx_data_i  (rx_data_i)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_status();
        return {28'b0, m_rx_ovf, m_tx_ovf, rx_q.size() != 0, m_tx_cnt < 16};
    endfunction

    // One bus cycle: drive at negedge, sample load data before the edge
    task automatic bus(input bit ce, input bit we, input bit a2, input logic [31:0] wd,
                       input logic [3:0] sel, input bit rxv, input logic [7:0] rxd,
                       output logic [31:0] rdata);
        @(negedge clk);
        ce_i = ce; we_i = we; addr_i = {29'b0, a2, 2'b0};
        data_i = wd; sel_i = sel; rx_valid_i = rxv; rx_data_i = rxd;
        #1 rdata = data_o;
        @(posedge clk);
        #1;
        ce_i = 1'b0; we_i = 1'b0; rx_valid_i = 1'b0;
    endtask

    // Optional RX byte arriving in the same cycle as a DATA load (or idle)
    task automatic rx_cycle(input bit do_read, input bit rxv, input logic [7:0] b);
        logic [31:0] r;
        logic [31:0] exp;
        exp = (do_read && rx_q.size() != 0) ? {24'b0, rx_q[0]} : 32'h0;
        bus(do_read, 1'b0, 1'b0, 32'h0, 4'hF, rxv, b, r);
        if (do_read) begin
            check("data_read", r, exp);
            if (rx_q.size() != 0) void'(rx_q.pop_front());
        end
        if (rxv) begin
            if (rx_q.size() < 16) rx_q.push_back(b);
            else m_rx_ovf = 1'b1;
        end
    endtask

    task automatic rd_status(input string tag);
        logic [31:0] r;
        bus(1'b1, 1'b0, 1'b1, 32'h0, 4'hF, 1'b0, 8'h0, r);
        check(tag, r, exp_status());
    endtask

    task automatic wr_data(input logic [7:0] b);
        logic [31:0] r;
        bus(1'b1, 1'b1, 1'b0, {24'hABCDEF, b}, 4'hF, 1'b0, 8'h0, r);
        if (m_tx_cnt >= 16) m_tx_ovf = 1'b1;
        else begin
            m_tx_cnt++;
            tx_exp.push_back(b);
        end
    endtask

    task automatic wr_status(input logic [31:0] wd, input logic [3:0] sel,
                             input bit rxv, input logic [7:0] rxd);
        logic [31:0] r;
        bit drop;
        bus(1'b1, 1'b1, 1'b1, wd, sel, rxv, rxd, r);
        drop = rxv && rx_q.size() >= 16;
        if (rxv && !drop) rx_q.push_back(rxd);
        if (sel[0]) begin
            if (wd[2]) m_tx_ovf = 1'b0;
            if (wd[3]) m_rx_ovf = 1'b0;
        end
        if (drop) m_rx_ovf = 1'b1;
    endtask

    task automatic wait_tx(input int n, input int budget);
        int k = 0;
        while (tx_seen.size() < n && k < budget) begin
            @(posedge clk);
            k++;
        end
        #1;
        check("tx_pulse_count", tx_seen.size(), n);
    endtask

    // Pulses seen must match accepted stores in order; both lists are then cleared
    task automatic compare_tx(input string tag);
        check({tag, "_count"}, tx_seen.size(), tx_exp.size());
        for (int i = 0; i < tx_exp.size() && i < tx_seen.size(); i++) begin
            check({tag, "_byte"}, {24'b0, tx_seen[i]}, {24'b0, tx_exp[i]});
        end
        tx_seen.delete();
        tx_exp.delete();
        m_tx_cnt = 0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int gap;
        int n;
        int n0;
        logic [31:0] r;

        rst = 1'b1; hold_busy = 1'b0;
        ce_i = 0; we_i = 0; addr_i = 0; sel_i = 0; data_i = 0;
        rx_valid_i = 0; rx_data_i = 0;
        m_tx_ovf = 0; m_rx_ovf = 0; m_tx_cnt = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_tx_start", {31'b0, tx_start_o}, 32'h0);
        check("rst_tx_data", {24'b0, tx_data_o}, 32'h0);
        check("idle_bus_data", data_o, 32'h0);
        rd_status("rst_status");
        check("rst_status_value", exp_status(), 32'h1);
        rx_cycle(1'b1, 1'b0, 8'h0);
        rd_status("status_after_empty_read");

        // Two stores back-to-back; first start 2 cycles after its push
        wr_data(8'h41);
        wr_data(8'h42);
        @(negedge clk);
        check("tx1_not_yet", {31'b0, tx_start_o}, 32'h0);
        @(negedge clk);
        check("tx1_pulse", {31'b0, tx_start_o}, 32'h1);
        check("tx1_data", {24'b0, tx_data_o}, 32'h41);
        gap = 0;
        do begin
            @(negedge clk);
            gap++;
        end while (!tx_start_o && gap < 60);
        check("tx2_pulse", {31'b0, tx_start_o}, 32'h1);
        check("tx2_data", {24'b0, tx_data_o}, 32'h42);
        check("tx2_after_busy", {31'b0, (gap > 10 && busy_cnt == 0)}, 32'h1);
        repeat (20) @(posedge clk);
        compare_tx("tx_directed");

        // Random burst of stores drains in order
        n = $urandom_range(3, 6);
        for (int i = 0; i < n; i++) wr_data(8'($urandom));
        wait_tx(n, 400);
        repeat (20) @(posedge clk);
        compare_tx("tx_random");

        // Fill TX FIFO with the transmitter held busy, then overflow it
        hold_busy = 1'b1;
        repeat (2) @(posedge clk);
        for (int i = 0; i < 16; i++) wr_data(8'($urandom));
        rd_status("tx_full_status");
        wr_data(8'($urandom));
        rd_status("tx_ovf_status");
        wr_status(32'h4, 4'b1110, 1'b0, 8'h0);
        rd_status("tx_ovf_sel_ignored");
        wr_status(32'h4, 4'b0001, 1'b0, 8'h0);
        rd_status("tx_ovf_cleared");
        hold_busy = 1'b0;
        wait_tx(16, 500);
        repeat (20) @(posedge clk);
        compare_tx("tx_drain");
        rd_status("tx_drained_status");

        // RX directed then random mixes
        rx_cycle(1'b0, 1'b1, 8'h55);
        rx_cycle(1'b0, 1'b1, 8'hAA);
        rd_status("rx_avail_status");
        rx_cycle(1'b1, 1'b0, 8'h0);
        rx_cycle(1'b1, 1'b0, 8'h0);
        rd_status("rx_empty_status");
        rx_cycle(1'b0, 1'b1, 8'($urandom));
        rx_cycle(1'b1, 1'b1, 8'($urandom));
        rx_cycle(1'b1, 1'b0, 8'h0);
        rx_cycle(1'b1, 1'b0, 8'h0);
        rd_status("rx_mix_status");

        // RX overflow, coincident clear, and full-with-pop acceptance
        for (int i = 0; i < 16; i++) rx_cycle(1'b0, 1'b1, 8'($urandom));
        rd_status("rx_full_status");
        rx_cycle(1'b0, 1'b1, 8'h77);
        rd_status("rx_ovf_status");
        wr_status(32'h8, 4'b0001, 1'b1, 8'h99);
        rd_status("rx_ovf_clear_vs_set");
        wr_status(32'h8, 4'b0001, 1'b0, 8'h0);
        rd_status("rx_ovf_cleared");
        rx_cycle(1'b1, 1'b1, 8'h77);
        rd_status("rx_full_pop_push");
        check("rx_model_count", rx_q.size(), 16);
        for (int i = 0; i < 16; i++) rx_cycle(1'b1, 1'b0, 8'h0);
        rx_cycle(1'b1, 1'b0, 8'h0);
        rd_status("rx_final_empty");

        // Reset while waiting for busy to fall with bytes still queued
        for (int i = 0; i < 4; i++) wr_data(8'($urandom));
        wait_tx(1, 50);
        repeat (4) @(posedge clk);
        n0 = tx_seen.size();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_tx_start", {31'b0, tx_start_o}, 32'h0);
        check("rst_mid_tx_data", {24'b0, tx_data_o}, 32'h0);
        rx_q.delete(); tx_exp.delete();
        m_tx_ovf = 0; m_rx_ovf = 0; m_tx_cnt = 0;
        rd_status("rst_mid_status");
        rst = 1'b0;
        repeat (80) @(posedge clk);
        #1;
        check("no_pulse_after_rst", tx_seen.size(), n0);
        rd_status("post_rst_status");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
